// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer for a registered-read instruction ROM with valid/ready delivery, redirects and halt
module instr_fetch_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_req,
  output logic              halted,
  output logic [31:0]       fetch_count
);
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  state_t            state, state_n;
  logic [ADDR_W-1:0] f_pc, f_pc_n, inf_pc, inf_pc_n;
  logic              inf_v, inf_v_n, stall, accept;
  assign stall       = inf_v & ~instr_ready;
  assign instr_valid = inf_v & ~redirect_valid;
  assign accept      = instr_valid & instr_ready;
  assign instr_pc    = inf_pc;
  assign instr_out   = mem_rdata;
  assign halted      = state == HALT;
  assign mem_addr    = redirect_valid ? redirect_addr : stall ? inf_pc : f_pc;
  // next fetch state: redirect first, then issue, stall hold, or halt entry
  always_comb begin
    state_n  = state;
    f_pc_n   = f_pc;
    inf_pc_n = inf_pc;
    inf_v_n  = inf_v;
    if (redirect_valid) begin
      inf_v_n  = 1'b1;
      inf_pc_n = redirect_addr;
      f_pc_n   = redirect_addr + 1'b1;
      state_n  = RUN;
    end else if (state == BOOT || (state == RUN && !stall && !halt_req)) begin
      inf_v_n  = 1'b1;
      inf_pc_n = f_pc;
      f_pc_n   = f_pc + 1'b1;
      state_n  = RUN;
    end else if (state == RUN && !stall) begin
      inf_v_n  = 1'b0;
      state_n  = HALT;
    end
  end
  // state, PC pipeline and accepted-fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      f_pc        <= RST_PC;
      inf_pc      <= RST_PC;
      inf_v       <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      f_pc        <= f_pc_n;
      inf_pc      <= inf_pc_n;
      inf_v       <= inf_v_n;
      fetch_count <= fetch_count + 32'(accept);
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: per-cycle vector table plus accept scoreboard for instr_fetch_ctrl
module tb_instr_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  mem_addr, instr_pc, redirect_addr = '0;
  logic [31:0] mem_rdata, instr_out, fetch_count;
  logic        instr_valid, instr_ready = 1'b1, redirect_valid = 1'b0, halt_req = 1'b0, halted;
  int          n_tests = 0, n_fail = 0;
  logic [9:0]  sb[$];

  typedef struct {
    logic        rdy, rv;
    logic [9:0]  ra;
    logic        hr, ev;
    logic [9:0]  epc, ema;
    logic        eh;
    logic [31:0] ecnt;
  } vec_t;
  vec_t seg1[$], seg2[$];

  instr_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .halt_req(halt_req), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // ROM model: ROM[i] = i + 0x100, one-cycle registered read
  always @(posedge clk) mem_rdata <= 32'(mem_addr) + 32'h100;

  // scoreboard: every accept must match the oldest expected accepted pc
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL accept_unexpected pc=%h", instr_pc);
      end else begin
        logic [9:0] p;
        p = sb.pop_front();
        if (instr_pc !== p || instr_out !== 32'(p) + 32'h100) begin
          n_fail++;
          $display("FAIL accept pc=%h data=%h expected pc=%h data=%h", instr_pc, instr_out, p, 32'(p) + 32'h100);
        end
      end
    end
  end

  task automatic drive(input vec_t v);
    instr_ready    = v.rdy;
    redirect_valid = v.rv;
    redirect_addr  = v.ra;
    halt_req       = v.hr;
    if (v.ev && v.rdy) sb.push_back(v.epc);
  endtask

  task automatic check(input string nm, input vec_t v);
    n_tests++;
    if (instr_valid !== v.ev || instr_pc !== v.epc || mem_addr !== v.ema || halted !== v.eh ||
        fetch_count !== v.ecnt || (v.ev && instr_out !== 32'(v.epc) + 32'h100)) begin
      n_fail++;
      $display("FAIL %s got v=%b pc=%h ma=%h h=%b cnt=%0d out=%h expected v=%b pc=%h ma=%h h=%b cnt=%0d",
               nm, instr_valid, instr_pc, mem_addr, halted, fetch_count, instr_out,
               v.ev, v.epc, v.ema, v.eh, v.ecnt);
    end
  endtask

  task automatic run(input string nm, input vec_t t[$]);
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      check($sformatf("%s[%0d]", nm, i), t[i]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t v;
    // rdy rv ra hr | ev epc ema eh cnt
    seg1.push_back('{1, 0, 10'h000, 0, 0, 10'h000, 10'h000, 0, 0});   // BOOT bubble
    for (int k = 1; k <= 5; k++)
      seg1.push_back('{1, 0, 10'h000, 0, 1, 10'(k - 1), 10'(k), 0, 32'(k - 1)});
    seg1.push_back('{0, 0, 10'h000, 0, 1, 10'h005, 10'h005, 0, 5});   // stall x3 at pc 5
    seg1.push_back('{0, 0, 10'h000, 0, 1, 10'h005, 10'h005, 0, 5});
    seg1.push_back('{0, 0, 10'h000, 0, 1, 10'h005, 10'h005, 0, 5});
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h005, 10'h006, 0, 5});
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h006, 10'h007, 0, 6});
    seg1.push_back('{1, 1, 10'h200, 0, 0, 10'h007, 10'h200, 0, 7});   // redirect squashes pc 7
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h200, 10'h201, 0, 7});
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h201, 10'h202, 0, 8});
    seg1.push_back('{1, 1, 10'h3FE, 0, 0, 10'h202, 10'h3FE, 0, 9});   // redirect near top
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h3FE, 10'h3FF, 0, 9});
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h3FF, 10'h000, 0, 10});  // wrap
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h000, 10'h001, 0, 11});
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h001, 10'h002, 0, 12});
    seg1.push_back('{1, 0, 10'h000, 1, 1, 10'h002, 10'h003, 0, 13});  // halt with accept
    seg1.push_back('{1, 0, 10'h000, 0, 0, 10'h002, 10'h003, 1, 14});
    seg1.push_back('{1, 0, 10'h000, 0, 0, 10'h002, 10'h003, 1, 14});
    seg1.push_back('{1, 1, 10'h010, 0, 0, 10'h002, 10'h010, 1, 14});  // redirect leaves HALT
    seg1.push_back('{1, 0, 10'h000, 0, 1, 10'h010, 10'h011, 0, 14});
    seg1.push_back('{0, 0, 10'h000, 1, 1, 10'h011, 10'h011, 0, 15});  // halt while stalled: deferred
    seg1.push_back('{1, 0, 10'h000, 1, 1, 10'h011, 10'h012, 0, 15});
    seg1.push_back('{1, 0, 10'h000, 0, 0, 10'h011, 10'h012, 1, 16});
    seg1.push_back('{1, 1, 10'h009, 0, 0, 10'h011, 10'h009, 1, 16});  // redirect to 9
    // after mid-stall reset: T1 restart then T5 halt after 4 accepts
    seg2.push_back('{1, 0, 10'h000, 0, 0, 10'h000, 10'h000, 0, 0});
    for (int k = 1; k <= 3; k++)
      seg2.push_back('{1, 0, 10'h000, 0, 1, 10'(k - 1), 10'(k), 0, 32'(k - 1)});
    seg2.push_back('{1, 0, 10'h000, 1, 1, 10'h003, 10'h004, 0, 3});
    seg2.push_back('{1, 0, 10'h000, 0, 0, 10'h003, 10'h004, 1, 4});
    seg2.push_back('{1, 1, 10'h010, 0, 0, 10'h003, 10'h010, 1, 4});
    seg2.push_back('{1, 0, 10'h000, 0, 1, 10'h010, 10'h011, 0, 4});

    #1;
    v = '{1, 0, 10'h000, 0, 0, 10'h000, 10'h000, 0, 0};
    check("reset", v);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run("seq", seg1);
    // stall at pc 9, then async reset mid-cycle
    v = '{0, 0, 10'h000, 0, 1, 10'h009, 10'h009, 0, 16};
    drive(v);
    #1;
    check("stall9", v);
    #1;
    rst_n = 1'b0;
    #1;
    v = '{0, 0, 10'h000, 0, 0, 10'h000, 10'h000, 0, 0};
    check("async_reset", v);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run("restart", seg2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
